// File: rtl/mem_stage.sv
//==============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage with a DEPTH x 32 little-endian data memory,
//               byte/half/word loads and stores, and misalignment detection.
//               Optional wait-state FSM enabled by macro MEM_WAIT_STATE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [1:0]  mem_size_m,
    input  logic        mem_unsigned_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] store_data_m,
    output logic [31:0] read_data_m,
    output logic        stall_m,
    output logic        misaligned_m
);

    localparam int c_AW = $clog2(DEPTH);

    // Contents survive reset; only the time-zero image is defined.
    logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

    logic [c_AW+1:0] w_addr;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_word;
    logic            w_rd;
    logic            w_wr;
    logic [1:0]      w_size;
    logic            w_uns;
    logic [31:0]     w_data;
    logic            w_mis;
    logic            w_load_done;
    logic            w_we;
    logic            w_stall;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == 2'b01 && a[0]) || (size[1] && a != 2'b00);
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [1:0] size, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00:   r[{a, 3'b000} +: 8]     = data[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = data[15:0];
            default: r                        = data;
        endcase
        return r;
    endfunction

`ifdef MEM_WAIT_STATE_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic            r_rd;
    logic            r_wr;
    logic            r_uns;
    logic [1:0]      r_size;
    logic [c_AW+1:0] r_addr;
    logic [31:0]     r_data;
    logic            w_latch;
    logic            w_sel_latched;
    logic            w_complete;
    logic            w_req_ok;

    assign w_mis    = (r_state == S_IDLE) && (mem_read_m || mem_write_m)
                      && is_misaligned(mem_size_m, alu_result_m[1:0]);
    assign w_req_ok = (mem_read_m || mem_write_m) && !w_mis;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_latch       = 1'b0;
        w_sel_latched = 1'b0;
        w_complete    = 1'b0;
        w_stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_ok) begin
                    // With zero wait states the access completes in the request cycle.
                    if (c_WAIT == 4'd0) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_latch     = 1'b1;
                        w_cnt_nxt   = c_WAIT;
                        w_state_nxt = (c_WAIT == 4'd1) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd2) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_sel_latched = 1'b1;
                w_complete    = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_data  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_rd   <= mem_read_m;
                r_wr   <= mem_write_m;
                r_uns  <= mem_unsigned_m;
                r_size <= mem_size_m;
                r_addr <= alu_result_m[c_AW+1:0];
                r_data <= store_data_m;
            end
        end
    end

    assign w_rd        = w_sel_latched ? r_rd   : mem_read_m;
    assign w_wr        = w_sel_latched ? r_wr   : mem_write_m;
    assign w_size      = w_sel_latched ? r_size : mem_size_m;
    assign w_uns       = w_sel_latched ? r_uns  : mem_unsigned_m;
    assign w_addr      = w_sel_latched ? r_addr : alu_result_m[c_AW+1:0];
    assign w_data      = w_sel_latched ? r_data : store_data_m;
    assign w_load_done = w_complete && w_rd && !w_wr;
    assign w_we        = w_complete && w_wr;
`else
    assign w_rd        = mem_read_m;
    assign w_wr        = mem_write_m;
    assign w_size      = mem_size_m;
    assign w_uns       = mem_unsigned_m;
    assign w_addr      = alu_result_m[c_AW+1:0];
    assign w_data      = store_data_m;
    assign w_mis       = (w_rd || w_wr) && is_misaligned(w_size, w_addr[1:0]);
    assign w_load_done = w_rd && !w_wr && !w_mis;
    assign w_we        = w_wr && !w_mis;
    assign w_stall     = 1'b0;
`endif

    // Address bits above the array wrap and are deliberately ignored.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, alu_result_m[31:c_AW+2]};

    assign w_idx  = w_addr[c_AW+1:2];
    assign w_word = r_mem[w_idx];

    assign read_data_m  = (!reset && w_load_done) ? extract(w_word, w_size, w_uns, w_addr[1:0]) : 32'h0;
    assign misaligned_m = !reset && w_mis;
    assign stall_m      = !reset && w_stall;

    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            r_mem[w_idx] <= merge(w_word, w_data, w_size, w_addr[1:0]);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//==============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: byte-array reference model
//               with per-cycle comparison, literal anchors and random traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [1:0]  mem_size_m;
    logic        mem_unsigned_m;
    logic [31:0] alu_result_m;
    logic [31:0] store_data_m;
    logic [31:0] read_data_m;
    logic        stall_m;
    logic        misaligned_m;

    int checks = 0;
    int errors = 0;

    byte unsigned mb [4*DEPTH];

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read_m    (mem_read_m),
        .mem_write_m   (mem_write_m),
        .mem_size_m    (mem_size_m),
        .mem_unsigned_m(mem_unsigned_m),
        .alu_result_m  (alu_result_m),
        .store_data_m  (store_data_m),
        .read_data_m   (read_data_m),
        .stall_m       (stall_m),
        .misaligned_m  (misaligned_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic int byte_base(input logic [31:0] a);
        return int'(a % 32'(4*DEPTH));
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int b;
        logic [31:0] v;
        b = byte_base(a);
        if (sz == 2'b00) begin
            v = {24'h0, mb[b]};
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = {16'h0, mb[b+1], mb[b]};
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int b;
        int n;
        b = byte_base(a);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) mb[b+i] = d[8*i +: 8];
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        mem_read_m     = rd;
        mem_write_m    = wr;
        mem_size_m     = sz;
        mem_unsigned_m = uns;
        alu_result_m   = a;
        store_data_m   = d;
    endtask

    // One request per cycle; returns mid-cycle so literal checks can follow.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        drive(rd, wr, sz, uns, a, d);
        @(negedge clk);
        #1;
    endtask

`ifndef MEM_WAIT_STATE_EN
    always @(negedge clk) begin
        logic        mis;
        logic [31:0] exp_rd;
        if (reset) begin
            mis    = 1'b0;
            exp_rd = 32'h0;
        end else begin
            mis = (mem_read_m || mem_write_m) &&
                  ((mem_size_m == 2'b01 && alu_result_m[0]) ||
                   (mem_size_m >= 2'b10 && alu_result_m[1:0] != 2'b00));
            exp_rd = (mem_read_m && !mem_write_m && !mis)
                     ? model_load(mem_size_m, mem_unsigned_m, alu_result_m) : 32'h0;
        end
        check("cyc_read_data", read_data_m, exp_rd);
        check("cyc_misaligned", {31'h0, misaligned_m}, {31'h0, mis});
        check("cyc_stall", {31'h0, stall_m}, 32'h0);
        if (!reset && mem_write_m && !mis) model_store(mem_size_m, alu_result_m, store_data_m);
    end
`endif

    initial begin
        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
        reset = 1'b1;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h1111_1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_misaligned", {31'h0, misaligned_m}, 32'h0);
        check("rst_read_data", read_data_m, 32'h0);
        check("rst_stall", {31'h0, stall_m}, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;

`ifndef MEM_WAIT_STATE_EN
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("st_word_rd_zero", read_data_m, 32'h0);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("ld_word_10", read_data_m, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        check("ld_byte_11_s", read_data_m, 32'hFFFF_FFBE);
        op(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        check("ld_byte_11_u", read_data_m, 32'h0000_00BE);
        op(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check("ld_half_12_s", read_data_m, 32'hFFFF_DEAD);
        op(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAA_AA55);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("ld_after_sb", read_data_m, 32'h55AD_BEEF);
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h410, 32'hCAFE_F00D);
        op(1'b1, 1'b0, 2'b11, 1'b1, 32'h10, 32'h0);
        check("ld_alias_410", read_data_m, 32'hCAFE_F00D);
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h1122_3344);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        check("mis_ld_flag", {31'h0, misaligned_m}, 32'h1);
        check("mis_ld_data", read_data_m, 32'h0);
        check("mis_ld_stall", {31'h0, stall_m}, 32'h0);
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFF_FFFF);
        check("mis_st_flag", {31'h0, misaligned_m}, 32'h1);
        op(1'b1, 1'b0, 2'b01, 1'b1, 32'h05, 32'h0);
        check("mis_half_flag", {31'h0, misaligned_m}, 32'h1);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        check("ld_04_intact", read_data_m, 32'h1122_3344);
        op(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0BAD_F00D);
        check("rdwr_rd_zero", read_data_m, 32'h0);
        op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0);
        check("ld_half_0a_u", read_data_m, 32'h0000_0BAD);

        for (int n = 0; n < 600; n++) begin
            op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
               $urandom & 32'hFFFF_F03F, $urandom);
        end
`else
        // Store DEADBEEF at 0x10: request, WAIT, DONE.
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("w_st_req_stall", {31'h0, stall_m}, 32'h1);
        @(posedge clk); #1;
        check("w_st_wait_stall", {31'h0, stall_m}, 32'h1);
        @(posedge clk); #1;
        check("w_st_done_stall", {31'h0, stall_m}, 32'h0);
        check("w_st_done_rd", read_data_m, 32'h0);
        // Load with the address changed mid-wait.
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("w_ld_req_stall", {31'h0, stall_m}, 32'h1);
        check("w_ld_req_rd", read_data_m, 32'h0);
        @(posedge clk); #1;
        alu_result_m = 32'h40;
        check("w_ld_wait_stall", {31'h0, stall_m}, 32'h1);
        check("w_ld_wait_rd", read_data_m, 32'h0);
        @(posedge clk); #1;
        check("w_ld_done_stall", {31'h0, stall_m}, 32'h0);
        check("w_ld_done_rd", read_data_m, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        check("w_mis_flag", {31'h0, misaligned_m}, 32'h1);
        check("w_mis_stall", {31'h0, stall_m}, 32'h0);
        check("w_mis_rd", read_data_m, 32'h0);
        // Store aborted by reset during WAIT.
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678);
        check("w_rs_req_stall", {31'h0, stall_m}, 32'h1);
        @(posedge clk); #1;
        check("w_rs_wait_stall", {31'h0, stall_m}, 32'h1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        check("w_rs_abort_stall", {31'h0, stall_m}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("w_rs_ld_stall", {31'h0, stall_m}, 32'h0);
        check("w_rs_ld_rd", read_data_m, 32'h0);
`endif

        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
